// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: turns operation descriptors into 32-bit machine words,
// substitutes a flagged NOP for unencodable descriptors and can append padding NOPs.
module rv32i_inst_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  input  logic [3:0]       in_pad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] emit_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [3:0] CL_R      = 4'd0;
  localparam logic [3:0] CL_OPIMM  = 4'd1;
  localparam logic [3:0] CL_LOAD   = 4'd2;
  localparam logic [3:0] CL_STORE  = 4'd3;
  localparam logic [3:0] CL_BRANCH = 4'd4;
  localparam logic [3:0] CL_LUI    = 4'd5;
  localparam logic [3:0] CL_AUIPC  = 4'd6;
  localparam logic [3:0] CL_JAL    = 4'd7;
  localparam logic [3:0] CL_JALR   = 4'd8;
  localparam logic [3:0] CL_FENCE  = 4'd9;
  localparam logic [3:0] CL_SYSTEM = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_ACCEPT,
    ST_PAD
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] pad_cnt;
  logic       slot_free;
  logic       accept;

  logic        fits_i12;
  logic        fits_b13;
  logic        fits_j21;
  logic        is_shift;
  logic        sys_priv_ok;
  logic [11:0] opimm_field;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [31:0] load_word;

  // A signed immediate fits an N-bit field when all bits above the sign bit equal it.
  assign fits_i12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits_b13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign fits_j21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // ECALL, EBREAK, SRET, MRET, WFI are the only funct12 values accepted with funct3=000.
  assign sys_priv_ok = (in_imm[11:0] == 12'h000) || (in_imm[11:0] == 12'h001) ||
                       (in_imm[11:0] == 12'h102) || (in_imm[11:0] == 12'h302) ||
                       (in_imm[11:0] == 12'h105);

  assign opimm_field = is_shift ? {1'b0, in_alt, 5'b00000, in_imm[4:0]} : in_imm[11:0];

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (in_class)
      CL_R: begin
        enc_word = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
        enc_err  = in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      end
      CL_OPIMM: begin
        enc_word = {opimm_field, in_rs1, in_funct3, in_rd, OP_OPIMM};
        enc_err  = is_shift ? (in_imm[31:5] != '0) : !fits_i12;
      end
      CL_LOAD: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        enc_err  = !fits_i12 || (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
                   (in_funct3 == 3'b111);
      end
      CL_STORE: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        enc_err  = !fits_i12 || (in_funct3 > 3'b010);
      end
      CL_BRANCH: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_err  = !fits_b13 || in_imm[0] || (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
      end
      CL_LUI: begin
        enc_word = {in_imm[31:12], in_rd, OP_LUI};
        enc_err  = (in_imm[11:0] != '0);
      end
      CL_AUIPC: begin
        enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
        enc_err  = (in_imm[11:0] != '0);
      end
      CL_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_err  = !fits_j21 || in_imm[0];
      end
      CL_JALR: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
        enc_err  = !fits_i12 || (in_funct3 != 3'b000);
      end
      CL_FENCE: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_FENCE};
        enc_err  = (in_funct3 != 3'b000);
      end
      CL_SYSTEM: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_SYSTEM};
        enc_err  = (in_funct3 == 3'b100) || ((in_funct3 == 3'b000) && !sys_priv_ok);
      end
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign load_word = enc_err ? NOP : enc_word;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ST_ACCEPT: begin
        in_ready = slot_free;
        if (in_valid && slot_free && (in_pad != 4'd0)) begin
          state_next = ST_PAD;
        end
      end
      ST_PAD: begin
        if (slot_free && (pad_cnt == 4'd1)) begin
          state_next = ST_ACCEPT;
        end
      end
    endcase
  end

  // Output slot: a new word replaces the old one only when the slot is free, so a
  // stalled word stays put until the downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
      pad_cnt   <= '0;
      emit_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_inst  <= load_word;
        out_err   <= enc_err;
        pad_cnt   <= in_pad;
      end else if ((state == ST_PAD) && slot_free) begin
        out_valid <= 1'b1;
        out_inst  <= NOP;
        out_err   <= 1'b0;
        pad_cnt   <= pad_cnt - 4'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) begin
        emit_cnt <= emit_cnt + 1'b1;
      end

      if (accept && enc_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Self-checking bench for rv32i_inst_encoder: directed test-plan cases plus
// randomized descriptors scored against a field-arithmetic reference model.
module tb_rv32i_inst_encoder;

  localparam int CNT_W = 16;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_class = '0;
  logic [2:0]       in_funct3 = '0;
  logic             in_alt = 1'b0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [31:0]      in_imm = '0;
  logic [3:0]       in_pad = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] emit_cnt;
  logic [ERR_W-1:0] err_cnt;

  int          compare_count = 0;
  int          fail_count = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_word;
  int          model_emit = 0;
  int          model_err = 0;
  logic [31:0] last_inst = '0;
  logic        last_err = 1'b0;
  int          ready_mode = 0;

  int edge_imms[15] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                        1048574, 1048575, -1048576, -1048578, 31, 32, 0};
  int sys_ok[5] = '{'h000, 'h001, 'h102, 'h302, 'h105};

  rv32i_inst_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pad(in_pad),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .emit_cnt(emit_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference encoder: builds each word from field values with shifts and modulo,
  // and judges legality from the signed value of the immediate.
  function automatic logic [32:0] refEncode(input int cls, input int f3, input int alt,
                                            input int rd, input int rs1, input int rs2,
                                            input logic [31:0] imm);
    int          s;
    int          lo12;
    logic [31:0] u;
    logic [31:0] w;
    bit          bad;
    s    = $signed(imm);
    u    = imm;
    lo12 = int'(u & 32'hFFF);
    w    = 32'h13;
    bad  = 1'b0;
    case (cls)
      0: begin
        bad = (alt != 0) && (f3 != 0) && (f3 != 5);
        w = (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      end
      1: begin
        if (f3 == 1 || f3 == 5) begin
          bad = (u >> 5) != 0;
          w = (alt << 30) | ((u % 32) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end else begin
          bad = (s < -2048) || (s > 2047);
          w = (lo12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end
      end
      2: begin
        bad = (s < -2048) || (s > 2047) || f3 == 3 || f3 == 6 || f3 == 7;
        w = (lo12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
      end
      3: begin
        bad = (s < -2048) || (s > 2047) || f3 > 2;
        w = ((lo12 / 32) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
            ((lo12 % 32) << 7) | 'h23;
      end
      4: begin
        bad = (s < -4096) || (s > 4094) || ((u % 2) != 0) || f3 == 2 || f3 == 3;
        w = (((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((u >> 1) % 16) << 8) | (((u >> 11) % 2) << 7) | 'h63;
      end
      5, 6: begin
        bad = lo12 != 0;
        w = (u & 32'hFFFFF000) | (rd << 7) | ((cls == 5) ? 'h37 : 'h17);
      end
      7: begin
        bad = (s < -1048576) || (s > 1048574) || ((u % 2) != 0);
        w = (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21) | (((u >> 11) % 2) << 20) |
            (((u >> 12) % 256) << 12) | (rd << 7) | 'h6F;
      end
      8: begin
        bad = (s < -2048) || (s > 2047) || f3 != 0;
        w = (lo12 << 20) | (rs1 << 15) | (rd << 7) | 'h67;
      end
      9: begin
        bad = f3 != 0;
        w = (lo12 << 20) | (rs1 << 15) | (rd << 7) | 'h0F;
      end
      10: begin
        bad = (f3 == 4) ||
              (f3 == 0 && !(lo12 == 'h000 || lo12 == 'h001 || lo12 == 'h102 ||
                            lo12 == 'h302 || lo12 == 'h105));
        w = (lo12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h73;
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'h13;
    return {bad, w};
  endfunction

  // Scoreboard: observes both handshakes on the falling edge, ahead of the rising
  // edge at which they complete; outputs are popped before new accepts are pushed.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_emit = 0;
      model_err = 0;
    end else begin
      checkOutput("emit_cnt", 32'(emit_cnt), 32'(model_emit % (1 << CNT_W)));
      checkOutput("err_cnt", 32'(err_cnt), 32'(model_err));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_word", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_word = exp_q.pop_front();
          checkOutput("out_inst", out_inst, mon_word[31:0]);
          checkOutput("out_err", 32'(out_err), 32'(mon_word[32]));
        end
        last_inst = out_inst;
        last_err = out_err;
        model_emit++;
      end
      if (in_valid && in_ready) begin
        mon_word = refEncode(int'(in_class), int'(in_funct3), int'(in_alt), int'(in_rd),
                             int'(in_rs1), int'(in_rs2), in_imm);
        exp_q.push_back(mon_word);
        for (int k = 0; k < int'(in_pad); k++) exp_q.push_back({1'b0, 32'h13});
        if (mon_word[32] && model_err < ERR_MAX) model_err++;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic applyStimulus(input int cls, input int f3, input int alt, input int rd,
                               input int rs1, input int rs2, input logic [31:0] imm,
                               input int pad);
    bit accepted;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_class  = 4'(cls);
    in_funct3 = 3'(f3);
    in_alt    = 1'(alt);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    in_pad    = 4'(pad);
    accepted  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    checkOutput("accept_wait", 32'(accepted), 32'd1);
  endtask

  task automatic goIdle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    goIdle();
    done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_wait", 32'(done), 32'd1);
  endtask

  task automatic runDirected(input string tag, input int cls, input int f3, input int alt,
                             input int rd, input int rs1, input int rs2,
                             input logic [31:0] imm, input logic [31:0] want_inst,
                             input logic want_err);
    applyStimulus(cls, f3, alt, rd, rs1, rs2, imm, 0);
    drain();
    checkOutput({tag, "_inst"}, last_inst, want_inst);
    checkOutput({tag, "_err"}, 32'(last_err), 32'(want_err));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int ready_low;
    int cls, f3, alt, mode, pad;
    logic [31:0] imm;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_inst", out_inst, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_emit_cnt", 32'(emit_cnt), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] directed encodings");
    ready_mode = 0;
    runDirected("add", 0, 0, 0, 3, 1, 2, 32'd0, 32'h002081B3, 1'b0);
    checkOutput("add_emit", 32'(emit_cnt), 32'd1);
    runDirected("addi_m1", 1, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    runDirected("sw", 3, 2, 0, 0, 1, 2, 32'd8, 32'h0020A423, 1'b0);
    runDirected("beq_m4", 4, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    runDirected("addi_2048", 1, 0, 0, 1, 0, 0, 32'd2048, 32'h00000013, 1'b1);
    checkOutput("err_cnt_after_range", 32'(err_cnt), 32'd1);
    runDirected("branch_odd", 4, 0, 0, 0, 0, 0, 32'd3, 32'h00000013, 1'b1);
    checkOutput("err_cnt_after_odd", 32'(err_cnt), 32'd2);

    $display("[TB] padding");
    applyStimulus(1, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 2);
    goIdle();
    ready_low = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!in_ready) ready_low++;
    end
    checkOutput("pad_ready_low", 32'(ready_low), 32'd2);
    drain();
    checkOutput("pad_emit", 32'(emit_cnt), 32'd9);

    $display("[TB] backpressure");
    ready_mode = 2;
    @(posedge clk);
    applyStimulus(3, 2, 0, 0, 1, 2, 32'd8, 0);
    goIdle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_inst", out_inst, 32'h0020A423);
    end
    ready_mode = 0;
    drain();
    checkOutput("bp_emit", 32'(emit_cnt), 32'd10);

    $display("[TB] error counter saturation");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(11 + $urandom_range(0, 4), 0, 0, 1, 1, 1, $urandom(), 0);
    end
    drain();
    checkOutput("err_cnt_sat", 32'(err_cnt), 32'(ERR_MAX));

    $display("[TB] randomized descriptors");
    ready_mode = 1;
    for (int n = 0; n < 1500; n++) begin
      cls  = $urandom_range(0, 15);
      f3   = $urandom_range(0, 7);
      alt  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      mode = $urandom_range(0, 5);
      case (mode)
        0: imm = $urandom();
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = 32'(edge_imms[$urandom_range(0, 14)]);
        3: imm = $urandom() & 32'hFFFFF000;
        4: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: imm = 32'($urandom_range(0, 63));
      endcase
      if (mode == 4 && $urandom_range(0, 1) == 1) imm = imm & 32'hFFFFFFFE;
      if (cls == 10 && $urandom_range(0, 1) == 1) begin
        f3  = 0;
        imm = 32'(sys_ok[$urandom_range(0, 4)]);
      end
      pad = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(cls, f3, alt, $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), imm, pad);
    end
    ready_mode = 0;
    drain();

    $display("[TB] reset during padding");
    applyStimulus(1, 0, 0, 5, 0, 0, 32'd7, 3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstpad_valid", 32'(out_valid), 32'd0);
    checkOutput("rstpad_emit", 32'(emit_cnt), 32'd0);
    checkOutput("rstpad_err", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    runDirected("post_rst_add", 0, 0, 0, 3, 1, 2, 32'd0, 32'h002081B3, 1'b0);
    checkOutput("post_rst_emit", 32'(emit_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
- Encodes RV32I operation descriptors into 32-bit instruction words. This is the inverse of the decode tables in the RV32I instruction package.
- Used by the self-test and boot-program generator to stream machine code into instruction memory.
- Validates field ranges and replaces unencodable descriptors with NOP plus an error flag.
- Optionally appends a requested number of NOPs after each instruction for hazard padding.

Parameters:
- CNT_W, 16, width of emitted-instruction counter
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_class  in  4  0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 FENCE, 10 SYSTEM; 11-15 illegal
- in_funct3  in  3  funct3 field
- in_alt  in  1  sets inst[30] (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  in  5 each  register fields; rs1 carries zimm for CSR*I
- in_imm  in  32  byte-offset/immediate as a signed value; funct12 for SYSTEM funct3=000; CSR address for Zicsr
- in_pad  in  4  number of NOPs (0x00000013) to emit after this instruction
- out_valid  out  1  instruction word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_inst  out  32  encoded instruction
- out_err  out  1  qualifies out_inst: descriptor was unencodable and NOP was substituted
- emit_cnt  out  CNT_W  handshakes completed on the output
- err_cnt  out  ERR_W  errors detected

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset values: out_valid=0, out_inst=0, out_err=0, emit_cnt=0, err_cnt=0, state=ACCEPT, pad counter=0.
  - Reset mid-PAD aborts the remaining NOPs and drops any held word.
- Output register: single registered stage.
  - The slot is free when !out_valid || out_ready.
  - out_inst and out_err hold stable while out_valid && !out_ready.
- FSM state ACCEPT:
  - in_ready = slot free.
  - On accept: the encoded word (or NOP with out_err=1) is loaded next cycle, giving latency 1.
  - If in_pad != 0, load pad counter = in_pad and go to PAD.
- FSM state PAD:
  - in_ready=0.
  - Each cycle the slot is free, load 0x00000013 with out_err=0 and decrement the pad counter.
  - When a NOP is loaded with counter==1, return to ACCEPT.
- Encoding, opcodes per package:
  - R: {alt<<5 as funct7, rs2, rs1, f3, rd, 0110011}.
  - OP-IMM: imm[11:0].
    - For f3=001/101, imm[11:5] = {0, alt, 00000} and shamt = imm[4:0].
  - LOAD: I-format, opcode 0000011.
  - JALR: I-format, opcode 1100111, f3 must be 000.
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - LUI/AUIPC: {imm[31:12], rd, op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - FENCE: {imm[11:0], rs1, 000, rd, 0001111}.
  - SYSTEM: {imm[11:0], rs1, f3, rd, 1110011}.
- Error conditions (any one sets out_err; err_cnt increments on accept and saturates at all-ones):
  - class 11-15.
  - OP-IMM, LOAD, JALR, STORE with imm outside [-2048, 2047].
  - OP-IMM shift with imm[31:5] != 0.
  - BRANCH with imm outside [-4096, 4094] or imm[0]=1.
  - JAL with imm outside [-2^20, 2^20-2] or imm[0]=1.
  - LUI/AUIPC with imm[11:0] != 0.
  - LOAD f3 in {011, 110, 111}.
  - STORE f3 > 010.
  - BRANCH f3 in {010, 011}.
  - R-type with alt=1 and f3 not in {000, 101}.
  - SYSTEM f3=100.
  - SYSTEM f3=000 with imm[11:0] not in {ECALL, EBREAK, SRET, MRET, WFI}.
  - FENCE f3 != 000.
- An errored descriptor still honours in_pad.
- emit_cnt increments on each output handshake and wraps at 2^CNT_W.
- Accept and output handshake in the same cycle is legal (full throughput, 1 word/cycle).

Test Plan:
- R-type ADD: class=0, f3=0, alt=0, rd=3, rs1=1, rs2=2, out_ready=1 -> out_inst=0x002081B3 one cycle after accept, out_err=0, emit_cnt=1.
- Immediate forms:
  - ADDI x1,x0,-1 (class 1, imm=0xFFFFFFFF) -> 0xFFF00093.
  - SW x2,8(x1) (class 3, f3=010) -> 0x0020A423.
  - BEQ x0,x0,-4 -> 0xFE000EE3.
- Range error: ADDI with imm=2048 -> out_inst=0x00000013, out_err=1, err_cnt=1.
- Branch error: BRANCH with imm=3 (odd) -> NOP, out_err=1, err_cnt=2.
- Padding: ADDI with in_pad=2, out_ready=1 -> three consecutive words (instr, NOP, NOP); in_ready=0 for exactly 2 cycles; emit_cnt +3.
- Backpressure: hold out_ready=0 for 5 cycles after a valid word -> out_inst stable, in_ready=0; release -> single handshake, no word lost or duplicated.
- Reset in PAD: assert rst_n=0 mid-PAD -> out_valid=0 immediately (async), counters 0; after release the next descriptor encodes normally.
